alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
- Parametrised, handshaked, multi-cycle successor to the single-cycle datapath ALU.
- Keeps the existing ALU_control and bonus_control opcode map. Adds shifts, a full-width signed product (hi/lo) and registered, correctly computed cout/overflow flags.
- Sits between the ID/EX register and the EX stage result mux. The pipeline stalls while in_ready is low.

Parameters:
- WIDTH, 32, operand/result width in bits; must be ≥4 and a power of 2.
- SHW, $clog2(WIDTH), shift-amount width; derived, do not override.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset; sampled on the rising edge of clk_i.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request; high only in IDLE.
- src1  in  WIDTH  operand A, two's complement.
- src2  in  WIDTH  operand B, two's complement.
- ALU_control  in  4  opcode.
- bonus_control  in  3  compare mode, used when ALU_control=7.
- out_valid  out  1  result, hi and flags are valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  result (low half for MUL).
- hi  out  WIDTH  upper product half for MUL; 0 for every other opcode.
- zero  out  1  result==0.
- cout  out  1  carry out for ADD/SUB.
- overflow  out  1  signed overflow.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state←IDLE, in_ready←1, out_valid←0.
  - result, hi, cout, overflow←0; zero←1.
  - Any MUL in progress is aborted.
  - Applies regardless of in_valid/out_ready.
- States: IDLE, MUL, DONE.
- Accept: in_valid & in_ready on a rising edge. src1, src2, ALU_control and bonus_control are captured; later input changes are ignored.
- IDLE, non-MUL opcode accepted: the result is computed from captured operands → DONE. out_valid=1 on the next cycle (latency 1).
- IDLE, MUL (8) accepted → MUL state.
  - Radix-2 signed shift-add (Booth or equivalent) over WIDTH iterations, one per cycle.
  - → DONE after WIDTH cycles; out_valid is asserted WIDTH+1 cycles after accept.
- DONE:
  - out_valid=1; all outputs are held stable until out_ready=1.
  - On out_valid & out_ready → IDLE; out_valid drops the next cycle.
  - in_ready is low in DONE, so accept-to-accept is at least 2 cycles.
- Opcodes:
  - 0 AND, 1 OR.
  - 2 ADD, 6 SUB.
  - 3 SLL, 4 SRL, 5 SRA: src1 shifted by src2[SHW-1:0]; upper src2 bits are ignored.
  - 7 compare: result = 1 or 0.
  - 8 MUL: {hi,result} = signed 2·WIDTH product.
  - 12 NOR, 13 NAND.
- Compare modes (signed unless noted):
  - 000 lt, 001 gt, 010 le, 011 ge.
  - 100 ne, 110 eq.
  - 101 ge against (src2-1) with WIDTH-bit wrap, so src2=MIN gives MAX.
  - 111 unsigned lt.
- Illegal opcode or mode: result=0, hi=0, cout=0, overflow=0, zero=1. The op still completes with latency 1.
- Arithmetic and flags:
  - ADD: {cout,result} = src1 + src2, unsigned WIDTH+1.
  - SUB: {cout,result} = src1 + ~src2 + 1; cout=1 means no borrow (e.g. 5-3 gives cout=1, 3-5 gives cout=0).
  - overflow, ADD: sign(src1)==sign(src2) and sign(result)≠sign(src1).
  - overflow, SUB: sign(src1)≠sign(src2) and sign(result)≠sign(src1).
  - overflow, MUL: 1 when hi is not the sign-extension of result[WIDTH-1].
  - cout=0 for all non-ADD/SUB opcodes; overflow=0 for all except ADD/SUB/MUL.
  - zero is computed from result only (hi is ignored).
- Boundaries:
  - in_valid asserted in MUL or DONE: ignored; the request must be held by the source.
  - out_ready asserted while out_valid=0: no effect.
  - rst_n low during MUL or DONE: reset wins and the pending result is lost.

Test Plan:
- Reset then ADD 0x7FFFFFFF+1 → result 0x80000000, overflow=1, cout=0, zero=0, out_valid 1 cycle after accept.
- SUB 3-5 → result 0xFFFFFFFE, cout=0, overflow=0. SUB 0x80000000-1 → 0x7FFFFFFF, overflow=1, cout=1.
- MUL -3 × 7 → result 0xFFFFFFEB, hi 0xFFFFFFFF, overflow=0, out_valid exactly 33 cycles after accept. MUL 0x10000×0x10000 → result 0, hi 1, overflow=1, zero=1.
- Compares with src1=-1, src2=1:
  - mode 000 → 1; mode 111 → 0; mode 110 → 0.
  - mode 101 with src2=0x80000000 → 0.
- Shifts with src1=0x80000001: SRA by 4 → 0xF8000000; SRL with src2=0x24 → 0x08000000 (only 5 LSBs used).
- Backpressure:
  - Hold out_ready=0 for 5 cycles → result stable, in_ready=0, new in_valid not accepted.
  - Then out_ready=1 → IDLE next cycle.
  - rst_n=0 during cycle 10 of a MUL → out_valid stays 0, zero=1, in_ready=1 after reset.

Source files
------------

// File: rtl/alu_mc.sv
// Handshaked multi-cycle ALU: single-cycle logic/arith/shift/compare ops plus a
// radix-2 Booth signed multiplier producing a full-width {hi,result} product.
module alu_mc #(
    parameter int  WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic [3:0]       ALU_control,
    input  logic [2:0]       bonus_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             cout,
    output logic             overflow
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_e;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SLL  = 4'd3;
    localparam logic [3:0] OP_SRL  = 4'd4;
    localparam logic [3:0] OP_SRA  = 4'd5;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_CMP  = 4'd7;
    localparam logic [3:0] OP_MUL  = 4'd8;
    localparam logic [3:0] OP_NOR  = 4'd12;
    localparam logic [3:0] OP_NAND = 4'd13;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d, hi_q, hi_d;
    logic             zero_q, zero_d, cout_q, cout_d, ovf_q, ovf_d;
    logic [WIDTH-1:0] mcand_q, mcand_d, mq_q, mq_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic             qm1_q, qm1_d;
    logic [SHW-1:0]   cnt_q, cnt_d;

    logic [WIDTH:0]   add_sum, sub_sum, mcand_x, acc_sum, acc_nx;
    logic [WIDTH-1:0] src2_m1, res_c, mq_nx;
    logic [SHW-1:0]   shamt;
    logic             cmp_c, cout_c, ovf_c, qm1_nx;

    assign add_sum = {1'b0, src1} + {1'b0, src2};
    assign sub_sum = {1'b0, src1} + {1'b0, ~src2} + (WIDTH+1)'(1);
    assign src2_m1 = src2 - WIDTH'(1);
    assign shamt   = src2[SHW-1:0];

    always_comb begin
        case (bonus_control)
            3'b000:  cmp_c = $signed(src1) <  $signed(src2);
            3'b001:  cmp_c = $signed(src1) >  $signed(src2);
            3'b010:  cmp_c = $signed(src1) <= $signed(src2);
            3'b011:  cmp_c = $signed(src1) >= $signed(src2);
            3'b100:  cmp_c = src1 != src2;
            3'b101:  cmp_c = $signed(src1) >= $signed(src2_m1);
            3'b110:  cmp_c = src1 == src2;
            3'b111:  cmp_c = src1 < src2;
            default: cmp_c = 1'b0;
        endcase
    end

    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
    always_comb begin
        res_c  = '0;
        cout_c = 1'b0;
        ovf_c  = 1'b0;
        case (ALU_control)
            OP_AND:  res_c = src1 & src2;
            OP_OR:   res_c = src1 | src2;
            OP_ADD: begin
                {cout_c, res_c} = add_sum;
                ovf_c = (src1[WIDTH-1] == src2[WIDTH-1]) && (add_sum[WIDTH-1] != src1[WIDTH-1]);
            end
            OP_SUB: begin
                {cout_c, res_c} = sub_sum;
                ovf_c = (src1[WIDTH-1] != src2[WIDTH-1]) && (sub_sum[WIDTH-1] != src1[WIDTH-1]);
            end
            OP_SLL:  res_c = src1 << shamt;
            OP_SRL:  res_c = src1 >> shamt;
            OP_SRA:  res_c = $signed(src1) >>> shamt;
            OP_CMP:  res_c = WIDTH'(cmp_c);
            OP_NOR:  res_c = ~(src1 | src2);
            OP_NAND: res_c = ~(src1 & src2);
            default: res_c = '0;
        endcase
    end

    // One Booth step; the accumulator is one bit wider so subtracting MIN cannot overflow.
    assign mcand_x = {mcand_q[WIDTH-1], mcand_q};

    always_comb begin
        case ({mq_q[0], qm1_q})
            2'b01:   acc_sum = acc_q + mcand_x;
            2'b10:   acc_sum = acc_q - mcand_x;
            default: acc_sum = acc_q;
        endcase
        {acc_nx, mq_nx, qm1_nx} = {acc_sum[WIDTH], acc_sum, mq_q};
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        hi_d     = hi_q;
        zero_d   = zero_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        mcand_d  = mcand_q;
        mq_d     = mq_q;
        acc_d    = acc_q;
        qm1_d    = qm1_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (ALU_control == OP_MUL) begin
                        state_d = S_MUL;
                        mcand_d = src1;
                        mq_d    = src2;
                        acc_d   = '0;
                        qm1_d   = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        state_d  = S_DONE;
                        result_d = res_c;
                        hi_d     = '0;
                        zero_d   = (res_c == '0);
                        cout_d   = cout_c;
                        ovf_d    = ovf_c;
                    end
                end
            end
            S_MUL: begin
                acc_d = acc_nx;
                mq_d  = mq_nx;
                qm1_d = qm1_nx;
                cnt_d = cnt_q + SHW'(1);
                if (cnt_q == SHW'(WIDTH-1)) begin
                    state_d  = S_DONE;
                    result_d = mq_nx;
                    hi_d     = acc_nx[WIDTH-1:0];
                    zero_d   = (mq_nx == '0);
                    cout_d   = 1'b0;
                    ovf_d    = (acc_nx[WIDTH-1:0] != {WIDTH{mq_nx[WIDTH-1]}});
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            hi_q     <= '0;
            zero_q   <= 1'b1;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            mcand_q  <= '0;
            mq_q     <= '0;
            acc_q    <= '0;
            qm1_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            hi_q     <= hi_d;
            zero_q   <= zero_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            mcand_q  <= mcand_d;
            mq_q     <= mq_d;
            acc_q    <= acc_d;
            qm1_q    <= qm1_d;
            cnt_q    <= cnt_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign hi        = hi_q;
    assign zero      = zero_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc: opcode/flag vectors, MUL latency,
// backpressure, back-to-back issue and reset during MUL/DONE.
module tb_alu_mc;

    localparam int W = 32;

    logic         clk_i = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic         in_ready, out_valid, zero, cout, overflow;
    logic [W-1:0] src1 = '0, src2 = '0, result, hi;
    logic [3:0]   ALU_control = '0;
    logic [2:0]   bonus_control = '0;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [2:0]  mode;
        logic [31:0] a, b, res, hi;
        logic        z, c, v;
        int          lat;
    } vec_t;

    alu_mc #(.WIDTH(W)) dut (
        .clk_i(clk_i), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .src1(src1), .src2(src2),
        .ALU_control(ALU_control), .bonus_control(bonus_control),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .hi(hi), .zero(zero), .cout(cout), .overflow(overflow)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(string n, logic [3:0] op, logic [2:0] mode, logic [31:0] a, logic [31:0] b,
                                logic [31:0] res, logic [31:0] h, logic z, logic c, logic v, int lat);
        vec_t t;
        t.name = n; t.op = op; t.mode = mode; t.a = a; t.b = b;
        t.res = res; t.hi = h; t.z = z; t.c = c; t.v = v; t.lat = lat;
        return t;
    endfunction

    // Issue one op from IDLE, scramble inputs after accept, wait for out_valid, then release it.
    task automatic run_op(input vec_t t, output logic [66:0] obs, output int lat);
        ALU_control = t.op; bonus_control = t.mode; src1 = t.a; src2 = t.b; in_valid = 1'b1;
        @(posedge clk_i); #1;
        in_valid = 1'b0; src1 = ~t.a; src2 = ~t.b; ALU_control = 4'd2; bonus_control = ~t.mode;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk_i); #1;
            lat++;
        end
        obs = {result, hi, zero, cout, overflow};
        out_ready = 1'b1;
        @(posedge clk_i); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        in_valid = 1'b1; ALU_control = 4'd2; src1 = 32'd1; src2 = 32'd1; out_ready = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        checks++;
        if ({in_ready, out_valid, result, hi, zero, cout, overflow} !== {1'b1, 1'b0, 64'd0, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_state got in_ready=%b out_valid=%b res=%h hi=%h z=%b c=%b v=%b exp 1 0 0 0 1 0 0",
                     in_ready, out_valid, result, hi, zero, cout, overflow);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        rst_n = 1'b1;
        @(posedge clk_i); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release got out_valid=%b in_ready=%b exp 0 1", out_valid, in_ready);
        end
    endtask

    task automatic run_table(input vec_t q[$]);
        logic [66:0] obs;
        int lat;
        foreach (q[i]) begin
            run_op(q[i], obs, lat);
            checks++;
            if (obs !== {q[i].res, q[i].hi, q[i].z, q[i].c, q[i].v} || lat != q[i].lat) begin
                failures++;
                $display("FAIL %s got res=%h hi=%h z=%b c=%b v=%b lat=%0d exp res=%h hi=%h z=%b c=%b v=%b lat=%0d",
                         q[i].name, obs[66:35], obs[34:3], obs[2], obs[1], obs[0], lat,
                         q[i].res, q[i].hi, q[i].z, q[i].c, q[i].v, q[i].lat);
            end
        end
    endtask

    task automatic test_add_sub;
        vec_t q[$];
        q.push_back(mk("add_ovf",   4'd2, 3'd0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0, 0, 0, 1, 1));
        q.push_back(mk("add_carry", 4'd2, 3'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0, 1, 1, 0, 1));
        q.push_back(mk("add_neg",   4'd2, 3'd0, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'hFFFFFFFB, 32'h0, 0, 1, 0, 1));
        q.push_back(mk("add_min",   4'd2, 3'd0, 32'h80000000, 32'h80000000, 32'h00000000, 32'h0, 1, 1, 1, 1));
        q.push_back(mk("sub_3m5",   4'd6, 3'd0, 32'd3,        32'd5,        32'hFFFFFFFE, 32'h0, 0, 0, 0, 1));
        q.push_back(mk("sub_5m3",   4'd6, 3'd0, 32'd5,        32'd3,        32'h00000002, 32'h0, 0, 1, 0, 1));
        q.push_back(mk("sub_minm1", 4'd6, 3'd0, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h0, 0, 1, 1, 1));
        q.push_back(mk("sub_maxmn", 4'd6, 3'd0, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h0, 0, 0, 1, 1));
        q.push_back(mk("sub_zero",  4'd6, 3'd0, 32'd7,        32'd7,        32'h00000000, 32'h0, 1, 1, 0, 1));
        run_table(q);
    endtask

    task automatic test_logic_shift;
        vec_t q[$];
        q.push_back(mk("and",     4'd0,  3'd0, 32'hF0F01234, 32'h0FF0FF00, 32'h00F01200, 32'h0, 0, 0, 0, 1));
        q.push_back(mk("or",      4'd1,  3'd0, 32'hF0F01234, 32'h0FF0FF00, 32'hFFF0FF34, 32'h0, 0, 0, 0, 1));
        q.push_back(mk("nor",     4'd12, 3'd0, 32'hF0F01234, 32'h0FF0FF00, 32'h000F00CB, 32'h0, 0, 0, 0, 1));
        q.push_back(mk("nand",    4'd13, 3'd0, 32'hF0F01234, 32'h0FF0FF00, 32'hFF0FEDFF, 32'h0, 0, 0, 0, 1));
        q.push_back(mk("sra_4",   4'd5,  3'd0, 32'h80000001, 32'h00000004, 32'hF8000000, 32'h0, 0, 0, 0, 1));
        q.push_back(mk("srl_24h", 4'd4,  3'd0, 32'h80000001, 32'h00000024, 32'h08000000, 32'h0, 0, 0, 0, 1));
        q.push_back(mk("sll_1",   4'd3,  3'd0, 32'h80000001, 32'h00000001, 32'h00000002, 32'h0, 0, 0, 0, 1));
        q.push_back(mk("sll_21h", 4'd3,  3'd0, 32'h80000001, 32'h00000021, 32'h00000002, 32'h0, 0, 0, 0, 1));
        q.push_back(mk("sra_31",  4'd5,  3'd0, 32'h80000001, 32'h0000001F, 32'hFFFFFFFF, 32'h0, 0, 0, 0, 1));
        q.push_back(mk("srl_0",   4'd4,  3'd0, 32'h80000001, 32'h00000000, 32'h80000001, 32'h0, 0, 0, 0, 1));
        q.push_back(mk("sra_pos", 4'd5,  3'd0, 32'h7FFFFFFF, 32'h00000004, 32'h07FFFFFF, 32'h0, 0, 0, 0, 1));
        run_table(q);
    endtask

    task automatic test_compare;
        vec_t q[$];
        q.push_back(mk("cmp_lt",     4'd7, 3'b000, 32'hFFFFFFFF, 32'd1, 32'd1, 32'h0, 0, 0, 0, 1));
        q.push_back(mk("cmp_gt",     4'd7, 3'b001, 32'hFFFFFFFF, 32'd1, 32'd0, 32'h0, 1, 0, 0, 1));
        q.push_back(mk("cmp_le",     4'd7, 3'b010, 32'hFFFFFFFF, 32'd1, 32'd1, 32'h0, 0, 0, 0, 1));
        q.push_back(mk("cmp_ge",     4'd7, 3'b011, 32'hFFFFFFFF, 32'd1, 32'd0, 32'h0, 1, 0, 0, 1));
        q.push_back(mk("cmp_ne",     4'd7, 3'b100, 32'hFFFFFFFF, 32'd1, 32'd1, 32'h0, 0, 0, 0, 1));
        q.push_back(mk("cmp_eq",     4'd7, 3'b110, 32'hFFFFFFFF, 32'd1, 32'd0, 32'h0, 1, 0, 0, 1));
        q.push_back(mk("cmp_eq_t",   4'd7, 3'b110, 32'd5,        32'd5, 32'd1, 32'h0, 0, 0, 0, 1));
        q.push_back(mk("cmp_ult",    4'd7, 3'b111, 32'hFFFFFFFF, 32'd1, 32'd0, 32'h0, 1, 0, 0, 1));
        q.push_back(mk("cmp_ult_t",  4'd7, 3'b111, 32'd1, 32'hFFFFFFFF, 32'd1, 32'h0, 0, 0, 0, 1));
        q.push_back(mk("cmp_gem1_w", 4'd7, 3'b101, 32'hFFFFFFFF, 32'h80000000, 32'd0, 32'h0, 1, 0, 0, 1));
        q.push_back(mk("cmp_gem1_t", 4'd7, 3'b101, 32'hFFFFFFFF, 32'h00000000, 32'd1, 32'h0, 0, 0, 0, 1));
        q.push_back(mk("cmp_gem1_m", 4'd7, 3'b101, 32'h80000000, 32'h80000000, 32'd0, 32'h0, 1, 0, 0, 1));
        run_table(q);
    endtask

    task automatic test_illegal;
        vec_t q[$];
        q.push_back(mk("ill_9",  4'd9,  3'd0, 32'd5,        32'd5,        32'd0, 32'h0, 1, 0, 0, 1));
        q.push_back(mk("ill_11", 4'd11, 3'd0, 32'h7FFFFFFF, 32'h00000001, 32'd0, 32'h0, 1, 0, 0, 1));
        q.push_back(mk("ill_15", 4'd15, 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'h0, 1, 0, 0, 1));
        run_table(q);
    endtask

    task automatic test_mul;
        vec_t q[$];
        q.push_back(mk("mul_m3x7",    4'd8, 3'd0, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFEB, 32'hFFFFFFFF, 0, 0, 0, 33));
        q.push_back(mk("mul_2p32",    4'd8, 3'd0, 32'h00010000, 32'h00010000, 32'h00000000, 32'h00000001, 1, 0, 1, 33));
        q.push_back(mk("mul_minxmin", 4'd8, 3'd0, 32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000, 1, 0, 1, 33));
        q.push_back(mk("mul_minxm1",  4'd8, 3'd0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 0, 0, 1, 33));
        q.push_back(mk("mul_m1xm1",   4'd8, 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 0, 0, 0, 33));
        q.push_back(mk("mul_x0",      4'd8, 3'd0, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000, 1, 0, 0, 33));
        run_table(q);
    endtask

    task automatic test_back_to_back;
        src1 = 32'd1; src2 = 32'd1; ALU_control = 4'd2; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk_i); #1;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (out_valid !== ((i % 2) == 0) || in_ready !== ((i % 2) == 1) || result !== 32'd2) begin
                failures++;
                $display("FAIL b2b_cycle%0d got out_valid=%b in_ready=%b res=%h exp out_valid=%b in_ready=%b res=2",
                         i, out_valid, in_ready, result, (i % 2) == 0, (i % 2) == 1);
            end
            @(posedge clk_i); #1;
        end
        in_valid = 1'b0;
        @(posedge clk_i); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        src1 = 32'd2; src2 = 32'd3; ALU_control = 4'd2; in_valid = 1'b1;
        @(posedge clk_i); #1;
        src1 = 32'd100; src2 = 32'd200; ALU_control = 4'd6;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'd5 || cout !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold%0d got out_valid=%b in_ready=%b res=%h c=%b exp 1 0 5 0",
                         i, out_valid, in_ready, result, cout);
            end
            @(posedge clk_i); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk_i); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release got out_valid=%b in_ready=%b exp 0 1", out_valid, in_ready);
        end
        out_ready = 1'b1;
        @(posedge clk_i); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'd5 || zero !== 1'b0) begin
            failures++;
            $display("FAIL bp_idle_ready got out_valid=%b in_ready=%b res=%h z=%b exp 0 1 5 0",
                     out_valid, in_ready, result, zero);
        end
    endtask

    task automatic test_reset_mid_op;
        int seen;
        src1 = 32'hFFFFFFFD; src2 = 32'd7; ALU_control = 4'd8; in_valid = 1'b1;
        @(posedge clk_i); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk_i);
        #1;
        rst_n = 1'b0;
        @(posedge clk_i); #1;
        rst_n = 1'b1;
        checks++;
        if ({out_valid, in_ready, zero, result, hi} !== {1'b0, 1'b1, 1'b1, 64'd0}) begin
            failures++;
            $display("FAIL rst_mul got out_valid=%b in_ready=%b z=%b res=%h hi=%h exp 0 1 1 0 0",
                     out_valid, in_ready, zero, result, hi);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_i); #1;
            if (out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL rst_mul_lost got valid_cycles=%0d exp 0", seen);
        end
        src1 = 32'd1; src2 = 32'd1; ALU_control = 4'd2; in_valid = 1'b1;
        @(posedge clk_i); #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk_i); #1;
        rst_n = 1'b1;
        checks++;
        if ({out_valid, in_ready, zero, result} !== {1'b0, 1'b1, 1'b1, 32'd0}) begin
            failures++;
            $display("FAIL rst_done got out_valid=%b in_ready=%b z=%b res=%h exp 0 1 1 0",
                     out_valid, in_ready, zero, result);
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_logic_shift();
        test_compare();
        test_illegal();
        test_mul();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
